// File: rtl/mm_pkg.sv
// Shared types and constants for the systolic matrix-multiplier control path.
package mm_pkg;

  localparam int DIM_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    WB     = 3'd4,
    FINISH = 3'd5
  } seq_state_t;

  // Cycles for the last partial sums to leave the array after the final operands enter it.
  function automatic int drain_cycles(input int h, input int w, input int rl);
    return h + w - 1 + rl;
  endfunction

endpackage

// File: rtl/mm_cfg_checker.sv
// Combinational job-descriptor validator: all dimensions nonzero and m/p aligned to the array.
module mm_cfg_checker
  import mm_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4
) (
  input  logic [DIM_W-1:0] cfg_m_i,
  input  logic [DIM_W-1:0] cfg_n_i,
  input  logic [DIM_W-1:0] cfg_p_i,
  output logic             cfg_ok
);

  // Both geometries are powers of two, so alignment reduces to a low-bit mask.
  localparam logic [DIM_W-1:0] M_MASK = DIM_W'(ARRAY_HEIGHT - 1);
  localparam logic [DIM_W-1:0] P_MASK = DIM_W'(ARRAY_WIDTH - 1);

  logic w_nonzero;
  logic w_aligned;

  assign w_nonzero = (cfg_m_i != '0) && (cfg_n_i != '0) && (cfg_p_i != '0);
  assign w_aligned = ((cfg_m_i & M_MASK) == '0) && ((cfg_p_i & P_MASK) == '0);
  assign cfg_ok    = w_nonzero && w_aligned;

endmodule

// File: rtl/matmul_sequencer.sv
// Job controller for the systolic multiplier: accept, launch generators, drain, write back, report.
module matmul_sequencer
  import mm_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [DIM_W-1:0] cfg_m_i,
  input  logic [DIM_W-1:0] cfg_n_i,
  input  logic [DIM_W-1:0] cfg_p_i,
  output logic [DIM_W-1:0] m_o,
  output logic [DIM_W-1:0] n_o,
  output logic [DIM_W-1:0] p_o,
  output logic             gen_start_o,
  input  logic             a_done_i,
  input  logic             b_done_i,
  output logic             array_clear_o,
  output logic             wb_start_o,
  input  logic             wb_done_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int               DRAIN_N  = drain_cycles(ARRAY_HEIGHT, ARRAY_WIDTH, READ_LATENCY);
  localparam int               CNT_W    = $clog2(DRAIN_N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             r_ready_en;
  logic             r_a_seen;
  logic             r_b_seen;
  logic             r_gen_start;
  logic             r_clear;
  logic             r_wb_start;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [DIM_W-1:0] r_m;
  logic [DIM_W-1:0] r_n;
  logic [DIM_W-1:0] r_p;
  logic             w_cfg_ok;
  logic             w_hs;
  logic             w_both_seen;

  mm_cfg_checker #(
    .ARRAY_HEIGHT(ARRAY_HEIGHT),
    .ARRAY_WIDTH (ARRAY_WIDTH)
  ) u_cfg_checker (
    .cfg_m_i(cfg_m_i),
    .cfg_n_i(cfg_n_i),
    .cfg_p_i(cfg_p_i),
    .cfg_ok (w_cfg_ok)
  );

  // Ready is held low while in reset and during the release cycle.
  assign cfg_ready_o = (r_state == IDLE) && r_ready_en;
  assign w_hs        = cfg_valid_i && cfg_ready_o;
  assign w_both_seen = (r_a_seen || a_done_i) && (r_b_seen || b_done_i);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs && w_cfg_ok) w_state_nxt = LAUNCH;
      LAUNCH:  w_state_nxt = RUN;
      RUN:     if (w_both_seen) w_state_nxt = DRAIN;
      DRAIN:   if (r_cnt == CNT_LAST) w_state_nxt = WB;
      WB:      if (wb_done_i) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort_i && (r_state != IDLE)) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ready_en  <= 1'b0;
      r_a_seen    <= 1'b0;
      r_b_seen    <= 1'b0;
      r_gen_start <= 1'b0;
      r_clear     <= 1'b0;
      r_wb_start  <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_m         <= '0;
      r_n         <= '0;
      r_p         <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready_en <= 1'b1;
      // Pulses fire on the transition itself, so an abort that redirects the FSM suppresses them.
      r_gen_start <= (r_state == LAUNCH) && (w_state_nxt == RUN);
      r_clear     <= (r_state == LAUNCH) && (w_state_nxt == RUN);
      r_wb_start  <= (r_state == DRAIN) && (w_state_nxt == WB);
      r_err       <= w_hs && !w_cfg_ok;

      if (w_hs && w_cfg_ok) begin
        r_m <= cfg_m_i;
        r_n <= cfg_n_i;
        r_p <= cfg_p_i;
      end

      if ((r_state == RUN) && (w_state_nxt == RUN)) begin
        r_a_seen <= r_a_seen || a_done_i;
        r_b_seen <= r_b_seen || b_done_i;
      end else begin
        r_a_seen <= 1'b0;
        r_b_seen <= 1'b0;
      end

      if ((r_state == RUN) && (w_state_nxt == DRAIN)) begin
        r_cnt <= CNT_LOAD;
      end else if (w_state_nxt == DRAIN) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign m_o           = r_m;
  assign n_o           = r_n;
  assign p_o           = r_p;
  assign gen_start_o   = r_gen_start;
  assign array_clear_o = r_clear;
  assign wb_start_o    = r_wb_start;
  assign err_o         = r_err;
  assign busy_o        = (r_state != IDLE);
  assign done_o        = (r_state == FINISH);

endmodule
